// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the program counter, fetches from the program ROM,
// predecodes control-flow words and presents a registered instruction plus
// a HOLD qualifier to the micro-instruction decoder.
//
// Handshake: there is no valid/ready pair. STALL is a level-sensitive wait.
// While it is high, every register (PC, instruction, state, stack) keeps its
// value, and HOLD tells the decoder to keep its previous micro-instruction.
module fetch_sequencer #(
    parameter int                 PC_W        = 11,
    parameter int                 INSTR_W     = 22,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [INSTR_W-1:0] NOP_WORD    = 22'b1111110000000000000000
) (
    input  logic               clk,
    input  logic               RST,
    output logic [PC_W-1:0]    PROG_ADDR,
    input  logic [INSTR_W-1:0] PROG_DATA,
    input  logic               STALL,
    input  logic               Z_FLAG,
    input  logic               P0_FLAG,
    input  logic               CY_FLAG,
    output logic [INSTR_W-1:0] instruction,
    output logic               HOLD,
    output logic               STACK_ERR
);

    // The pointer needs one extra bit so it can count 0..STACK_DEPTH.
    localparam int SP_W = $clog2(STACK_DEPTH) + 1;

    typedef enum logic [1:0] {
        S_BOOT    = 2'd0,
        S_RUN     = 2'd1,
        S_RESOLVE = 2'd2
    } state_t;

    state_t state;
    state_t state_next;

    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] cond_target;
    logic [1:0]      cond_sel;
    logic            cond_flag;
    logic [SP_W-1:0] sp;
    logic [PC_W-1:0] stack_mem [STACK_DEPTH];
    logic [SP_W-2:0] push_idx;
    logic [SP_W-2:0] pop_idx;
    logic            stack_full;
    logic            stack_empty;

    logic            is_jump;
    logic            is_cond;
    logic            is_bsr;
    logic            is_ret;
    logic [PC_W-1:0] j_target;
    logic [PC_W-1:0] b_target;

    // Predecode of the word currently addressed by the PC.
    assign is_jump  = (PROG_DATA[21:11] == 11'b10000000000);
    assign is_cond  = (PROG_DATA[21:11] == 11'b10100000000)
                    | (PROG_DATA[21:11] == 11'b11000000000)
                    | (PROG_DATA[21:11] == 11'b11100000000);
    assign is_bsr   = (PROG_DATA[21:10] == 12'b011100000000);
    assign is_ret   = (PROG_DATA == 22'b0000011000000000000000);
    assign j_target = PROG_DATA[PC_W-1:0];
    assign b_target = {1'b0, PROG_DATA[PC_W-2:0]};

    // PC arithmetic wraps naturally at the register width.
    assign pc_inc      = pc + PC_W'(1);
    assign PROG_ADDR   = pc;
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);
    assign push_idx    = sp[SP_W-2:0];
    assign pop_idx     = sp[SP_W-2:0] - 1'b1;

    // Bits [20:19] of a conditional word select the flag: 01=Z, 10=P0, 11=CY.
    always_comb begin
        case (cond_sel)
            2'b01:   cond_flag = Z_FLAG;
            2'b10:   cond_flag = P0_FLAG;
            default: cond_flag = CY_FLAG;
        endcase
    end

    // State register; reset drops any pending conditional resolution.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) state <= S_BOOT;
        else     state <= state_next;
    end

    // Next-state logic; STALL freezes every transition.
    always_comb begin
        state_next = state;
        if (!STALL) begin
            case (state)
                S_BOOT:    state_next = S_RUN;
                S_RUN:     if (is_cond) state_next = S_RESOLVE;
                S_RESOLVE: state_next = S_RUN;
                default:   state_next = S_BOOT;
            endcase
        end
    end

    // Decoder qualifier: hold while stalled or before the first fetch.
    always_comb begin
        HOLD = STALL || (state == S_BOOT);
    end

    // PC, instruction register, branch latch and return stack.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            pc          <= '0;
            instruction <= NOP_WORD;
            sp          <= '0;
            STACK_ERR   <= 1'b0;
            cond_sel    <= '0;
            cond_target <= '0;
            for (int i = 0; i < STACK_DEPTH; i++) stack_mem[i] <= '0;
        end else if (!STALL) begin
            case (state)
                S_RUN: begin
                    instruction <= PROG_DATA;
                    if (is_jump) begin
                        pc <= j_target;
                    end else if (is_bsr) begin
                        // A full stack drops the return address but still branches.
                        if (!stack_full) begin
                            stack_mem[push_idx] <= pc_inc;
                            sp                  <= sp + SP_W'(1);
                        end else begin
                            STACK_ERR <= 1'b1;
                        end
                        pc <= b_target;
                    end else if (is_ret) begin
                        // An empty stack falls through to the next word.
                        if (!stack_empty) begin
                            pc <= stack_mem[pop_idx];
                            sp <= sp - SP_W'(1);
                        end else begin
                            STACK_ERR <= 1'b1;
                            pc        <= pc_inc;
                        end
                    end else if (is_cond) begin
                        // PC stays put; the flag is judged one cycle later.
                        cond_sel    <= PROG_DATA[20:19];
                        cond_target <= j_target;
                    end else begin
                        pc <= pc_inc;
                    end
                end
                S_RESOLVE: begin
                    instruction <= NOP_WORD;
                    pc          <= cond_flag ? cond_target : pc_inc;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed sequences, a table of conditional
// branch vectors and randomized programs checked against a behavioural model.
module tb_fetch_sequencer;

    localparam logic [21:0] NOP   = 22'h3F0000;
    localparam logic [21:0] RET_W = 22'h018000;

    logic        clk = 1'b0;
    logic        RST;
    logic [10:0] PROG_ADDR;
    logic [21:0] PROG_DATA;
    logic        STALL;
    logic        Z_FLAG;
    logic        P0_FLAG;
    logic        CY_FLAG;
    logic [21:0] instruction;
    logic        HOLD;
    logic        STACK_ERR;

    logic [21:0] rom [2048];
    assign PROG_DATA = rom[PROG_ADDR];

    fetch_sequencer dut (
        .clk         (clk),
        .RST         (RST),
        .PROG_ADDR   (PROG_ADDR),
        .PROG_DATA   (PROG_DATA),
        .STALL       (STALL),
        .Z_FLAG      (Z_FLAG),
        .P0_FLAG     (P0_FLAG),
        .CY_FLAG     (CY_FLAG),
        .instruction (instruction),
        .HOLD        (HOLD),
        .STACK_ERR   (STACK_ERR)
    );

    // Clock
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Behavioural model: program counter, pending-branch record, stack as a queue.
    int          m_pc;
    logic [21:0] m_instr;
    bit          m_boot;
    bit          m_pend;
    int          m_tgt;
    int          m_flag;   // 0=Z, 1=P0, 2=CY
    bit          m_err;
    int          m_stack[$];

    typedef struct {
        int   op;       // 1=JZE, 2=JP0, 3=JCY
        logic z;
        logic p0;
        logic cy;
        int   exp_addr;
    } cond_vec_t;

    function automatic logic [21:0] w_seq(int a);
        return {11'h001, 11'(a)};
    endfunction

    // op: 0=JUMP, 1=JZE, 2=JP0, 3=JCY
    function automatic logic [21:0] w_jmp(int op, int t);
        logic [10:0] hi;
        hi = 11'h400 + 11'(op * 'h100);
        return {hi, 11'(t)};
    endfunction

    function automatic logic [21:0] w_bsr(int t);
        return {12'h700, 10'(t)};
    endfunction

    task automatic fill_seq();
        for (int a = 0; a < 2048; a++) rom[a] = w_seq(a);
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs();
        check("prog_addr", 32'(PROG_ADDR), 32'(m_pc));
        check("instruction", 32'(instruction), 32'(m_instr));
        check("hold", 32'(HOLD), 32'(STALL | m_boot));
        check("stack_err", 32'(STACK_ERR), 32'(m_err));
    endtask

    task automatic model_reset();
        m_pc = 0; m_instr = NOP; m_boot = 1; m_pend = 0;
        m_tgt = 0; m_flag = 0; m_err = 0;
        m_stack.delete();
    endtask

    // One rising edge of the model, using the inputs currently applied.
    task automatic model_step();
        logic [21:0] d;
        logic        f;
        if (STALL) return;
        if (m_boot) begin
            m_boot = 0;
        end else if (m_pend) begin
            m_instr = NOP;
            f = (m_flag == 0) ? Z_FLAG : (m_flag == 1) ? P0_FLAG : CY_FLAG;
            m_pc = f ? m_tgt : (m_pc + 1) % 2048;
            m_pend = 0;
        end else begin
            d = rom[m_pc];
            m_instr = d;
            if (d[21:11] == 11'h400) begin
                m_pc = int'(d[10:0]);
            end else if (d[21:11] == 11'h500 || d[21:11] == 11'h600 || d[21:11] == 11'h700) begin
                m_pend = 1;
                m_tgt  = int'(d[10:0]);
                m_flag = int'(d[21:11]) / 'h100 - 5;
            end else if (d[21:10] == 12'h700) begin
                if (m_stack.size() < 4) m_stack.push_back((m_pc + 1) % 2048);
                else m_err = 1;
                m_pc = int'(d[9:0]);
            end else if (d == RET_W) begin
                if (m_stack.size() > 0) m_pc = m_stack.pop_back();
                else begin
                    m_err = 1;
                    m_pc = (m_pc + 1) % 2048;
                end
            end else begin
                m_pc = (m_pc + 1) % 2048;
            end
        end
    endtask

    // Driver: advance one clock and compare everything against the model.
    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset(int n);
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs();
        repeat (n) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        RST = 1'b0;
    endtask

    task automatic run_to(int addr);
        int budget;
        budget = 3000;
        while (m_pc != addr && budget > 0) begin
            step();
            budget--;
        end
        if (budget == 0) check("run_to_timeout", 32'(PROG_ADDR), 32'(addr));
    endtask

    cond_vec_t cv[6];
    int        nest_exp[8];

    initial begin
        cv[0] = '{op: 1, z: 1'b1, p0: 1'b0, cy: 1'b0, exp_addr: 'h040};
        cv[1] = '{op: 1, z: 1'b0, p0: 1'b1, cy: 1'b1, exp_addr: 11};
        cv[2] = '{op: 2, z: 1'b0, p0: 1'b1, cy: 1'b0, exp_addr: 'h040};
        cv[3] = '{op: 2, z: 1'b1, p0: 1'b0, cy: 1'b1, exp_addr: 11};
        cv[4] = '{op: 3, z: 1'b0, p0: 1'b0, cy: 1'b1, exp_addr: 'h040};
        cv[5] = '{op: 3, z: 1'b1, p0: 1'b1, cy: 1'b0, exp_addr: 11};
        nest_exp = '{'h100, 'h200, 'h300, 'h380, 'h301, 'h201, 'h101, 2};

        STALL = 1'b0; Z_FLAG = 1'b0; P0_FLAG = 1'b0; CY_FLAG = 1'b0;

        // Reset and boot with a sequential program
        fill_seq();
        do_reset(3);
        check("reset_hold", 32'(HOLD), 32'd1);
        step();
        check("boot_addr", 32'(PROG_ADDR), 32'd0);
        check("boot_instr", 32'(instruction), 32'(NOP));
        repeat (6) step();
        check("seq_addr", 32'(PROG_ADDR), 32'd6);
        check("seq_instr", 32'(instruction), 32'(w_seq(5)));

        // Unconditional jump
        fill_seq();
        rom[5] = w_jmp(0, 'h123);
        do_reset(1);
        step();
        run_to(5);
        step();
        check("jump_target", 32'(PROG_ADDR), 32'h123);
        step();
        check("jump_next", 32'(PROG_ADDR), 32'h124);
        check("jump_no_bubble", 32'(instruction), 32'(w_seq('h123)));

        // Conditional branch table; flags are opposite during the fetch cycle
        for (int i = 0; i < 6; i++) begin
            fill_seq();
            rom[10] = w_jmp(cv[i].op, 'h040);
            do_reset(1);
            step();
            {Z_FLAG, P0_FLAG, CY_FLAG} = ~{cv[i].z, cv[i].p0, cv[i].cy};
            run_to(10);
            step();
            check("cond_fetch_addr", 32'(PROG_ADDR), 32'd10);
            {Z_FLAG, P0_FLAG, CY_FLAG} = {cv[i].z, cv[i].p0, cv[i].cy};
            step();
            check("cond_bubble", 32'(instruction), 32'(NOP));
            check("cond_target", 32'(PROG_ADDR), 32'(cv[i].exp_addr));
            {Z_FLAG, P0_FLAG, CY_FLAG} = 3'b000;
            step();
            check("cond_after", 32'(instruction), 32'(w_seq(cv[i].exp_addr)));
        end

        // Four nested calls, four returns, then a return on an empty stack
        fill_seq();
        rom[1] = w_bsr('h100); rom['h100] = w_bsr('h200);
        rom['h200] = w_bsr('h300); rom['h300] = w_bsr('h380);
        rom['h380] = RET_W; rom['h301] = RET_W; rom['h201] = RET_W;
        rom['h101] = RET_W; rom[2] = RET_W;
        do_reset(1);
        step();
        run_to(1);
        for (int i = 0; i < 8; i++) begin
            step();
            check("nest_addr", 32'(PROG_ADDR), 32'(nest_exp[i]));
            check("nest_err", 32'(STACK_ERR), 32'd0);
        end
        step();
        check("underflow_addr", 32'(PROG_ADDR), 32'd3);
        check("underflow_err", 32'(STACK_ERR), 32'd1);

        // Fifth call overflows: branch taken, push dropped
        rom['h380] = w_bsr('h3C0);
        rom['h3C0] = RET_W;
        do_reset(1);
        check("err_cleared", 32'(STACK_ERR), 32'd0);
        step();
        run_to(1);
        repeat (4) step();
        step();
        check("overflow_addr", 32'(PROG_ADDR), 32'h3C0);
        check("overflow_err", 32'(STACK_ERR), 32'd1);
        step();
        check("overflow_ret", 32'(PROG_ADDR), 32'h301);

        // Stall for three cycles while a conditional branch is resolving
        fill_seq();
        rom[10] = w_jmp(1, 'h040);
        do_reset(1);
        step();
        run_to(10);
        step();
        STALL = 1'b1;
        for (int i = 0; i < 3; i++) begin
            Z_FLAG = i[0];
            step();
            check("stall_addr", 32'(PROG_ADDR), 32'd10);
            check("stall_instr", 32'(instruction), 32'(w_jmp(1, 'h040)));
            check("stall_hold", 32'(HOLD), 32'd1);
        end
        STALL = 1'b0;
        Z_FLAG = 1'b1;
        step();
        check("stall_resolve", 32'(PROG_ADDR), 32'h040);
        Z_FLAG = 1'b0;

        // PC wrap: a sequential word at 2047, then a call at 2047 pushing 0
        for (int k = 0; k < 2; k++) begin
            fill_seq();
            rom[3] = w_jmp(0, 'h7FF);
            if (k == 1) begin
                rom['h7FF] = w_bsr('h010);
                rom['h010] = RET_W;
            end
            do_reset(1);
            step();
            run_to(3);
            step();
            check("wrap_at_top", 32'(PROG_ADDR), 32'h7FF);
            step();
            if (k == 0) begin
                check("wrap_seq", 32'(PROG_ADDR), 32'd0);
            end else begin
                check("wrap_call", 32'(PROG_ADDR), 32'h010);
                step();
                check("wrap_ret", 32'(PROG_ADDR), 32'd0);
            end
        end

        // Asynchronous reset between edges while resolving
        fill_seq();
        rom[10] = w_jmp(3, 'h050);
        do_reset(1);
        step();
        run_to(10);
        step();
        CY_FLAG = 1'b1;
        #3;
        RST = 1'b1;
        model_reset();
        #1;
        check_outputs();
        check("async_addr", 32'(PROG_ADDR), 32'd0);
        check("async_instr", 32'(instruction), 32'(NOP));
        check("async_hold", 32'(HOLD), 32'd1);
        @(posedge clk);
        #1;
        check_outputs();
        RST = 1'b0;
        step();
        step();
        check("post_async_addr", 32'(PROG_ADDR), 32'd1);
        CY_FLAG = 1'b0;

        // Randomized programs, stalls and flags against the model
        for (int a = 0; a < 2048; a++) begin
            case ($urandom_range(0, 9))
                5:       rom[a] = w_jmp(0, $urandom_range(0, 2047));
                6:       rom[a] = w_jmp($urandom_range(1, 3), $urandom_range(0, 2047));
                7:       rom[a] = w_bsr($urandom_range(0, 1023));
                8:       rom[a] = RET_W;
                default: rom[a] = w_seq($urandom_range(0, 2047));
            endcase
        end
        do_reset(2);
        for (int i = 0; i < 3000; i++) begin
            STALL   = ($urandom_range(0, 4) == 0);
            Z_FLAG  = 1'($urandom_range(0, 1));
            P0_FLAG = 1'($urandom_range(0, 1));
            CY_FLAG = 1'($urandom_range(0, 1));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
